// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state encoding, halt causes and decode helpers for core run control
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BOOT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4,
    ST_STEP   = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_DBG  = 2'd1;
  localparam logic [1:0] CAUSE_EBRK = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  // Fetch is blocked whenever the core must not pull new instructions
  function automatic logic hold_fetch(input state_t s);
    return (s == ST_IDLE) || (s == ST_BOOT) || (s == ST_DRAIN) || (s == ST_HALTED);
  endfunction

  // Stall seen by the core: memory busy while executing/draining, forced while halted
  function automatic logic stall_for(input state_t s, input logic mem_busy);
    case (s)
      ST_RUN, ST_STEP, ST_DRAIN: return mem_busy;
      ST_HALTED:                 return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/run_down_counter.sv
// rtl/run_down_counter.sv - loadable down counter with enable, saturating at zero
module run_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement only while enabled and not yet at zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run-control sequencer (boot, start handshake, halt/drain/step); cycle counter under CORE_RUN_CTRL_CYCLE_CNT_EN
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int BOOT_WAIT = 4,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             boot_en,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             dbg_halt_req,
  input  logic             dbg_resume_req,
  input  logic             dbg_step_req,
  input  logic             ebreak_halt,
  output logic             core_start,
  output logic             core_stall,
  output logic             fetch_hold,
  output logic             running,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int BW = $clog2(BOOT_WAIT + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);

  state_t state;
  state_t state_nx;
  logic   started;
  logic   mem_busy;
  logic   halt_req;
  logic   boot_load;
  logic   boot_dec;
  logic   boot_zero;
  logic   drain_load;
  logic   drain_dec;
  logic   drain_zero;

  // Next-state selection and counter controls
  always_comb begin
    mem_busy   = imem_busy | dmem_busy;
    halt_req   = ebreak_halt | dbg_halt_req;
    core_stall = stall_for(state, mem_busy);
    state_nx   = state;
    case (state)
      ST_IDLE:   if (boot_en) state_nx = ST_BOOT;
      ST_BOOT:   if (boot_zero) state_nx = ST_RUN;
      // a pending start must be accepted before a halt is honoured
      ST_RUN:    if (halt_req && !core_start) state_nx = ST_DRAIN;
      ST_DRAIN:  if (drain_zero && !mem_busy) state_nx = ST_HALTED;
      ST_HALTED: begin
        if (dbg_resume_req)    state_nx = ST_RUN;
        else if (dbg_step_req) state_nx = ST_STEP;
      end
      ST_STEP:   if (!mem_busy) state_nx = ST_DRAIN;
      default:   state_nx = ST_IDLE;
    endcase
    boot_load  = (state == ST_IDLE) && boot_en;
    boot_dec   = (state == ST_BOOT);
    drain_load = (state_nx == ST_DRAIN) && (state != ST_DRAIN);
    drain_dec  = (state == ST_DRAIN) && !core_stall;
  end

  run_down_counter #(.W(BW)) u_boot_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (boot_load),
    .load_val (BW'(BOOT_WAIT - 1)),
    .en       (boot_dec),
    .zero     (boot_zero)
  );

  run_down_counter #(.W(DW)) u_drain_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (drain_load),
    .load_val (DW'(DRAIN_CYC - 1)),
    .en       (drain_dec),
    .zero     (drain_zero)
  );

  // State register with registered start handshake, halt cause and fetch hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      core_start <= 1'b0;
      started    <= 1'b0;
      halt_cause <= CAUSE_NONE;
      fetch_hold <= 1'b0;
    end else begin
      state      <= state_nx;
      fetch_hold <= hold_fetch(state_nx);
      if (core_start && !core_stall) begin
        core_start <= 1'b0;
        started    <= 1'b1;
      end else if ((state == ST_BOOT) && (state_nx == ST_RUN) && !started) begin
        core_start <= 1'b1;
      end
      if ((state == ST_RUN) && (state_nx == ST_DRAIN)) begin
        halt_cause <= ebreak_halt ? CAUSE_EBRK : CAUSE_DBG;
      end else if ((state == ST_STEP) && (state_nx == ST_DRAIN)) begin
        halt_cause <= ebreak_halt ? CAUSE_EBRK : CAUSE_STEP;
      end else if ((state == ST_HALTED) && (state_nx == ST_RUN)) begin
        halt_cause <= CAUSE_NONE;
      end
    end
  end

  assign running = (state == ST_RUN) || (state == ST_STEP);
  assign halted  = (state == ST_HALTED);

`ifdef CORE_RUN_CTRL_CYCLE_CNT_EN
  // Count unstalled execution cycles; wraps naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
    end else if (running && !core_stall) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run-control sequencer for the RV32 core's activity FSM.
- After reset it waits a programmable boot delay, then issues the start request.
- Merges memory-busy sources into a single core stall, and services debug halt/resume/single-step and ebreak halts.
- Drains the pipeline with fetch held before reporting halted.
- Sits between the SoC/debug logic and the core's start/stall inputs.

Parameters:
- BOOT_WAIT, 4: cycles spent in BOOT before RUN (must be >= 1).
- DRAIN_CYC, 3: non-busy cycles needed to drain the pipeline on halt (must be >= 1).
- CNT_W, 32: width of the run-cycle counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  async active-low reset
- boot_en  in  1  permit leaving IDLE; sampled only in IDLE
- imem_busy  in  1  instruction memory busy
- dmem_busy  in  1  data memory busy
- dbg_halt_req  in  1  debug halt request (level)
- dbg_resume_req  in  1  debug resume request
- dbg_step_req  in  1  debug single-step request
- ebreak_halt  in  1  core retired ebreak; halt request
- core_start  out  1  start to core FSM; held until accepted
- core_stall  out  1  stall to core FSM
- fetch_hold  out  1  block new instruction fetch
- running  out  1  state is RUN or STEP
- halted  out  1  state is HALTED
- halt_cause  out  2  0 none, 1 debug, 2 ebreak, 3 step
- cycle_cnt  out  CNT_W  unstalled RUN/STEP cycles

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; counters 0; started flag 0. Reset mid-operation aborts immediately to IDLE.
- State register is encoded IDLE, BOOT, RUN, DRAIN, HALTED, STEP.
- core_stall by state: 0 in IDLE and BOOT; imem_busy|dmem_busy in RUN, STEP and DRAIN; 1 in HALTED.
- fetch_hold: 1 in IDLE, BOOT, DRAIN and HALTED; 0 in RUN and STEP.
- IDLE: boot_en=1 -> BOOT, wait counter loads BOOT_WAIT-1.
- BOOT: counter decrements each cycle; at 0 -> RUN.
- Start handshake:
  - core_start is registered. It rises on the first RUN cycle and stays high until a cycle with core_start=1 and core_stall=0 (accepted).
  - It drops the next cycle and sets the sticky started flag. No further start is issued until reset.
- RUN, halt requests:
  - ebreak_halt or dbg_halt_req -> DRAIN, drain counter loads DRAIN_CYC-1.
  - halt_cause = 2 if ebreak_halt, else 1; ebreak wins if both.
  - Halt is deferred while core_start is pending, i.e. not yet accepted.
- DRAIN:
  - Counter decrements only on cycles with core_stall=0.
  - When counter=0 and both busies are low -> HALTED.
  - Halt requests arriving in DRAIN are ignored; cause is not overwritten.
- HALTED:
  - dbg_resume_req -> RUN, halt_cause cleared to 0.
  - else dbg_step_req -> STEP; resume has priority over step.
  - dbg_halt_req held high does not block resume. After resume, if it is still high, RUN re-enters DRAIN next cycle (level semantics).
- STEP:
  - Remains while core_stall=1.
  - After exactly one unstalled cycle -> DRAIN with halt_cause=3.
  - An ebreak_halt in that cycle sets cause 2 instead.
- running and halted are decoded from the registered state; no combinational path from inputs to them.
- cycle_cnt increments when (RUN or STEP) and core_stall=0; wraps modulo 2^CNT_W; never cleared except by reset.

Optional Feature:
- Macro CORE_RUN_CTRL_CYCLE_CNT_EN.
- Defined: cycle_cnt counter implemented as above.
- Undefined: counter logic removed; cycle_cnt tied to 0; all other behaviour unchanged.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - the state encoding (3-bit enum constants ST_IDLE..ST_STEP);
  - halt_cause constants CAUSE_NONE=0, CAUSE_DBG=1, CAUSE_EBRK=2, CAUSE_STEP=3.
- One sub-module: run_down_counter, a loadable decrementer with enable and zero flag, instanced for the BOOT and DRAIN counts.

Test Plan:
- Boot: rstn released, boot_en=1, BOOT_WAIT=4, busies 0 -> BOOT 4 cycles; core_start high exactly 1 cycle on first RUN cycle; running=1.
- Start under stall: imem_busy=1 for 5 cycles at RUN entry -> core_start held 6 cycles and drops after the first cycle with core_stall=0; cycle_cnt stays 0 until then.
- Debug halt with drain: in RUN pulse dbg_halt_req; dmem_busy=1 for 2 cycles of DRAIN -> HALTED after 3 non-busy drain cycles; fetch_hold=1 throughout; halted=1; halt_cause=1.
- Simultaneous halt sources: ebreak_halt and dbg_halt_req same cycle -> halt_cause=2. Then resume and step together in HALTED -> RUN; cause 0.
- Single step: from HALTED pulse dbg_step_req with busies 0 -> exactly one RUN-like cycle (cycle_cnt +1), then DRAIN, then HALTED with halt_cause=3.
- Reset mid-DRAIN and counter wrap: rstn low in DRAIN -> all outputs 0 asynchronously, state IDLE. With CNT_W=4, 16 unstalled RUN cycles -> cycle_cnt wraps to 0. Without the macro, cycle_cnt stays 0.
